// File: rtl/fir_pkg.sv
// Shared constants and types for the dual-channel 8-parallel FIR input path.
package fir_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned CHANNELS   = 2;
    localparam int unsigned P_SAMPLES  = 8;
    localparam int unsigned BEAT_WIDTH = CHANNELS * P_SAMPLES * DATA_WIDTH;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    typedef enum logic {
        ST_FILL       = 1'b0,
        ST_FLUSH_WAIT = 1'b1
    } pack_state_t;

endpackage

// File: rtl/fir_beat_reg.sv
// Single-entry valid/ready output register. The owner may assert load only
// while out_free is high; the held word stays stable until it is taken.
module fir_beat_reg
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = BEAT_WIDTH
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             out_free,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data
);

    assign out_free = !valid || ready;

    // Hold until handshake; a load in the handshake cycle replaces the word.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fir_sample_packer.sv
// Packs P_SAMPLES consecutive sample pairs into one AXI-stream beat for the
// FIR input, newest sample in lane 0. Flush emits a zero-padded partial beat.
// Optional macro PACKER_TLAST_EN: frame beat counter driving m_tlast.
module fir_sample_packer #(
    parameter int unsigned DATA_WIDTH  = fir_pkg::DATA_WIDTH,
    parameter int unsigned CHANNELS    = fir_pkg::CHANNELS,
    parameter int unsigned P_SAMPLES   = fir_pkg::P_SAMPLES,
    parameter int unsigned FRAME_BEATS = 16
) (
    input  logic                                  clk,
    input  logic                                  nrst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_WIDTH-1:0]                 in_ch0,
    input  logic [DATA_WIDTH-1:0]                 in_ch1,
    input  logic                                  flush,
    output logic                                  m_tvalid,
    input  logic                                  m_tready,
    output logic [CHANNELS*P_SAMPLES*DATA_WIDTH-1:0] m_tdata,
    output logic                                  m_tlast
);

    import fir_pkg::*;

    localparam int unsigned BEAT_W = CHANNELS * P_SAMPLES * DATA_WIDTH;
    localparam int unsigned LCW    = $clog2(P_SAMPLES);
    localparam logic [LCW-1:0] LAST_LANE = LCW'(P_SAMPLES - 1);
`ifdef PACKER_TLAST_EN
    localparam int unsigned REG_W  = BEAT_W + 1;
    localparam int unsigned FCW    = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
`else
    localparam int unsigned REG_W  = BEAT_W;
`endif

    if (CHANNELS != 2 || P_SAMPLES < 2 || (P_SAMPLES & (P_SAMPLES - 1)) != 0 ||
        FRAME_BEATS < 1) begin : g_bad_cfg
        $error("fir_sample_packer: unsupported parameter set");
    end

    pack_state_t        state_q, state_d;
    logic [LCW-1:0]     lane_cnt;
    logic [BEAT_W-1:0]  asm_q, asm_wr;
    logic [REG_W-1:0]   reg_in, reg_out;
    logic               out_free, accept, grp_last, flush_partial;
    logic               load, load_flushed;

    assign in_ready      = nrst && (state_q == ST_FILL) && (lane_cnt != LAST_LANE || out_free);
    assign accept        = in_valid && in_ready;
    assign grp_last      = accept && (lane_cnt == LAST_LANE);
    assign flush_partial = flush && !grp_last && (lane_cnt != '0 || accept);

    // Assembly word including any sample accepted this cycle.
    // ~lane_cnt == P_SAMPLES-1-lane_cnt because P_SAMPLES is a power of two.
    always_comb begin
        asm_wr = asm_q;
        if (accept) begin
            for (int unsigned l = 0; l < P_SAMPLES; l++) begin
                if (LCW'(l) == ~lane_cnt) begin
                    asm_wr[DATA_WIDTH*l +: DATA_WIDTH]                      = in_ch0;
                    asm_wr[P_SAMPLES*DATA_WIDTH + DATA_WIDTH*l +: DATA_WIDTH] = in_ch1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= ST_FILL;
        else       state_q <= state_d;
    end

    // Next state and beat-load decision.
    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        load_flushed = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (grp_last) begin
                    load = 1'b1;
                end else if (flush_partial) begin
                    if (out_free) begin
                        load         = 1'b1;
                        load_flushed = 1'b1;
                    end else begin
                        state_d = ST_FLUSH_WAIT;
                    end
                end
            end
            ST_FLUSH_WAIT: begin
                if (out_free) begin
                    load         = 1'b1;
                    load_flushed = 1'b1;
                    state_d      = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Lane counter and assembly register; both restart on every beat load.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lane_cnt <= '0;
            asm_q    <= '0;
        end else if (load) begin
            lane_cnt <= '0;
            asm_q    <= '0;
        end else if (accept) begin
            lane_cnt <= lane_cnt + LCW'(1);
            asm_q    <= asm_wr;
        end
    end

`ifdef PACKER_TLAST_EN
    logic           flushed_q;
    logic [FCW-1:0] beat_cnt;

    assign reg_in    = {load_flushed, asm_wr};
    assign flushed_q = reg_out[BEAT_W];
    assign m_tlast   = m_tvalid && (flushed_q || beat_cnt == FCW'(FRAME_BEATS - 1));

    // Frame position counter, restarted after every tlast handshake.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            beat_cnt <= '0;
        end else if (m_tvalid && m_tready) begin
            beat_cnt <= m_tlast ? '0 : beat_cnt + FCW'(1);
        end
    end
`else
    assign reg_in  = asm_wr;
    assign m_tlast = 1'b0;
`endif

    assign m_tdata = reg_out[BEAT_W-1:0];

    fir_beat_reg #(
        .WIDTH (REG_W)
    ) u_beat_reg (
        .clk       (clk),
        .nrst      (nrst),
        .load      (load),
        .load_data (reg_in),
        .out_free  (out_free),
        .valid     (m_tvalid),
        .ready     (m_tready),
        .data      (reg_out)
    );

endmodule
